// File: rtl/ifetch_if.sv
// Fetch-stage bus: icache request/response and instruction-queue head.
// The master side is the fetch stage; the slave side is cache plus decoder.
interface ifetch_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ok;
  logic [31:0] icache_ins;
  logic        iq_pop;
  logic        iq_empty;
  logic [31:0] iq_ins;
  logic [31:0] iq_pc;
  logic        iq_jump;

  modport master (
    output icache_req, icache_addr,
    output iq_empty, iq_ins, iq_pc, iq_jump,
    input  icache_ok, icache_ins, iq_pop
  );

  modport slave (
    input  icache_req, icache_addr,
    input  iq_empty, iq_ins, iq_pc, iq_jump,
    output icache_ok, icache_ins, iq_pop
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: one outstanding icache request, predictor
// hookup, and a circular instruction queue popped by the decoder.
module ifetch #(
  parameter int IQ_LOG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  ifetch_if.master    bus,
  output logic [31:0] pred_pc,
  output logic [31:0] pred_ins,
  input  logic [31:0] pred_next,
  input  logic        pred_jump,
  input  logic        flush,
  input  logic [31:0] flush_pc
);
  localparam int DEPTH = 2**IQ_LOG;
  localparam logic [IQ_LOG:0] FULL =
    (IQ_LOG+1)'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_n;
  logic [31:0]       pc, pc_n;
  logic [31:0]       addr, addr_n;
  logic [IQ_LOG-1:0] head, head_n;
  logic [IQ_LOG-1:0] tail, tail_n;
  logic [IQ_LOG:0]   count, count_n;
  logic              push, pop, empty;

  logic [31:0] ins_q  [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic        jump_q [DEPTH];

  assign empty = (count == '0);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = addr;
    push    = 1'b0;
    pop     = 1'b0;
    if (flush) begin
      state_n = IDLE;
      pc_n    = flush_pc;
    end else begin
      unique case (state)
        IDLE: begin
          if (count < FULL) begin
            state_n = WAIT;
            addr_n  = pc;
          end
        end
        WAIT: begin
          if (bus.icache_ok) begin
            push    = 1'b1;
            pc_n    = pred_next;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
      pop = bus.iq_pop && !empty;
    end
  end

  // Flush wins over any push or pop in the same cycle.
  always_comb begin
    head_n  = head + IQ_LOG'(pop);
    tail_n  = tail + IQ_LOG'(push);
    count_n = count + (IQ_LOG+1)'(push)
                    - (IQ_LOG+1)'(pop);
    if (flush) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      addr  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      state <= state_n;
      pc    <= pc_n;
      addr  <= addr_n;
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && push) begin
      ins_q[tail]  <= bus.icache_ins;
      pc_q[tail]   <= pc;
      jump_q[tail] <= pred_jump;
    end
  end

  assign bus.icache_req  = (state == WAIT);
  assign bus.icache_addr = addr;
  assign bus.iq_empty    = empty;
  assign bus.iq_ins      = empty ? '0 : ins_q[head];
  assign bus.iq_pc       = empty ? '0 : pc_q[head];
  assign bus.iq_jump     = empty ? 1'b0 : jump_q[head];

  assign pred_pc  = pc;
  assign pred_ins = bus.icache_ins;
endmodule

// File: tb/tb_ifetch.sv
// Randomized scoreboard bench for ifetch: a cache/predictor stub feeds
// the DUT, a reference model predicts the queue stream and fetch PCs.
module tb_ifetch;
  localparam int NCYC = 1500;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        jump;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic [31:0] flush_pc;
  logic [31:0] pred_pc, pred_ins, pred_next;
  logic        pred_jump;
  logic [1:0]  bctr;

  ifetch_if bus ();

  ifetch #(.IQ_LOG(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus),
    .pred_pc(pred_pc), .pred_ins(pred_ins),
    .pred_next(pred_next), .pred_jump(pred_jump),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  // Program image: kind 0 addi, 1 jal, 2 beq
  logic [31:0] word [256];
  logic [31:0] off  [256];
  int          kind [256];

  ent_t        q[$];
  logic [31:0] exp_pc;
  int          pend;
  int          n_cmp, n_bad, n_pops;

  function automatic logic [31:0] enc_jal(logic [20:0] im);
    return {im[20], im[10:1], im[11], im[19:12],
            5'd0, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_beq(logic [12:0] im);
    return {im[12], im[10:5], 5'd0, 5'd0, 3'b000,
            im[4:1], im[11], 7'h63};
  endfunction

  // Predictor stub works from the instruction bits
  always_comb begin
    pred_jump = 1'b0;
    pred_next = pred_pc + 32'd4;
    if (pred_ins[6:0] == 7'h6f) begin
      pred_jump = 1'b1;
      pred_next = pred_pc + {{12{pred_ins[31]}},
        pred_ins[19:12], pred_ins[20],
        pred_ins[30:21], 1'b0};
    end else if (pred_ins[6:0] == 7'h63 && bctr >= 2) begin
      pred_jump = 1'b1;
      pred_next = pred_pc + {{20{pred_ins[31]}},
        pred_ins[7], pred_ins[30:25],
        pred_ins[11:8], 1'b0};
    end
  end

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fill_mem();
    int r, o;
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 9));
      o = (int'($urandom_range(0, 64)) - 32) * 4;
      if (o == 0) o = 8;
      off[i] = 32'(o);
      if (r < 7) begin
        kind[i] = 0;
        word[i] = {12'($urandom), 5'd1, 3'b000,
                   5'd1, 7'h13};
      end else if (r < 8) begin
        kind[i] = 1;
        word[i] = enc_jal(21'(o));
      end else begin
        kind[i] = 2;
        word[i] = enc_beq(13'(o));
      end
    end
    kind[0] = 0; word[0] = 32'h0010_8093;
    kind[1] = 0; word[1] = 32'h0010_8093;
    kind[2] = 1; off[2] = 32'h100;
    word[2] = enc_jal(21'h100);
    kind[8] = 2; off[8] = -32'sd8;
    word[8] = enc_beq(-13'sd8);
  endtask

  task automatic drive(int ncyc);
    bit   busy = 0;
    bit   prev_ok = 0;
    bit   ok;
    bit   jmp;
    int   lat = 0;
    int   rlow = 0;
    int   pr;
    logic [7:0] idx;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (!bus.icache_req) busy = 0;
      else if (!busy) begin
        busy = 1;
        prev_ok = 0;
        lat = int'($urandom_range(0, 3));
        check("req_addr", bus.icache_addr, exp_pc);
      end
      bctr = 2'($urandom_range(0, 3));
      if (rlow > 0) begin
        rdy = 1'b0; rlow--;
      end else if ($urandom_range(0, 29) == 0) begin
        rdy = 1'b0; rlow = 2;
      end else rdy = 1'b1;
      flush = 1'b0;
      if (rdy && (c < 300 || c >= 600) &&
          $urandom_range(0, 59) == 0) begin
        flush = 1'b1;
        flush_pc = {22'd0, 8'($urandom_range(0, 255)),
                    2'b00};
      end
      pr = (c >= 600) ? 70 : 40;
      if (c >= 300 && c < 600) bus.iq_pop = 1'b0;
      else bus.iq_pop = ($urandom_range(0, 99) < pr);
      if (!rdy) bus.iq_pop = 1'b1;
      ok = busy && (prev_ok || lat == 0);
      if (busy && !ok) lat--;
      idx = bus.icache_addr[9:2];
      bus.icache_ok  = ok;
      bus.icache_ins = ok ? word[idx] : $urandom;
      prev_ok = ok;
      pend = 0;
      if (flush) begin
        q.delete();
        exp_pc = flush_pc;
      end else if (ok && rdy) begin
        jmp = (kind[idx] == 1) ||
              (kind[idx] == 2 && bctr >= 2);
        q.push_back('{ins: word[idx],
                      pc: bus.icache_addr, jump: jmp});
        exp_pc = jmp ? bus.icache_addr + off[idx]
                     : bus.icache_addr + 32'd4;
        pend = 1;
      end
    end
  endtask

  task automatic monitor(int ncyc);
    bit          have = 0;
    logic        p_rdy, p_flush, p_req, p_ok, p_empty;
    logic [31:0] p_addr, p_ipc, p_ins, p_ppc;
    int          p_cnt, cnt;
    ent_t        e;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cnt = q.size() - pend;
      if (have) begin
        if (!p_rdy) begin
          check("frz_req", 32'(bus.icache_req), 32'(p_req));
          check("frz_addr", bus.icache_addr, p_addr);
          check("frz_empty", 32'(bus.iq_empty),
                32'(p_empty));
          check("frz_iqpc", bus.iq_pc, p_ipc);
          check("frz_iqins", bus.iq_ins, p_ins);
          check("frz_pc", pred_pc, p_ppc);
        end else if (p_flush) begin
          check("flush_req", 32'(bus.icache_req), 0);
          check("flush_empty", 32'(bus.iq_empty), 1);
        end else begin
          if (!p_req && p_cnt < 16)
            check("issue", 32'(bus.icache_req), 1);
          if (p_req && p_ok)
            check("req_drop", 32'(bus.icache_req), 0);
        end
      end
      if (!flush) begin
        check("empty", 32'(bus.iq_empty), 32'(cnt == 0));
        if (cnt >= 16)
          check("full_idle", 32'(bus.icache_req), 0);
        if (bus.iq_empty)
          check("iq_zero", bus.iq_ins | bus.iq_pc |
                32'(bus.iq_jump), 0);
      end
      if (rdy && !flush && bus.iq_pop && !bus.iq_empty) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop_model: got entry want none");
        end else begin
          e = q.pop_front();
          n_pops++;
          check("pop_ins", bus.iq_ins, e.ins);
          check("pop_pc", bus.iq_pc, e.pc);
          check("pop_jump", 32'(bus.iq_jump), 32'(e.jump));
        end
      end
      have    = 1;
      p_rdy   = rdy;
      p_flush = flush;
      p_req   = bus.icache_req;
      p_ok    = bus.icache_ok;
      p_empty = bus.iq_empty;
      p_addr  = bus.icache_addr;
      p_ipc   = bus.iq_pc;
      p_ins   = bus.iq_ins;
      p_ppc   = pred_pc;
      p_cnt   = cnt;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_pops = 0; pend = 0;
    exp_pc = '0;
    fill_mem();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    flush_pc = '0; bctr = '0;
    bus.icache_ok = 1'b0; bus.icache_ins = '0;
    bus.iq_pop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.icache_req), 0);
    check("rst_addr", bus.icache_addr, 0);
    check("rst_empty", 32'(bus.iq_empty), 1);
    check("rst_pc", pred_pc, 0);
    check("rst_iq", bus.iq_ins | bus.iq_pc |
          32'(bus.iq_jump), 0);
    rst = 1'b0;
    @(negedge clk);
    check("first_idle", 32'(bus.icache_req), 0);
    @(posedge clk); #1;
    check("first_req", 32'(bus.icache_req), 1);
    fork
      drive(NCYC);
      monitor(NCYC);
    join
    check("pops_seen", 32'(n_pops > 50), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
